// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, even parity, one stop bit, mid-bit sampling.
// The asynchronous line is double-flopped before any use.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_data_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             rxs_dly_q, rxs_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  logic rxs;
  logic fall;
  logic tick;

  assign rxs  = sync_q[1];
  assign fall = rxs_dly_q & ~rxs;
  // The start bit is checked at half a bit period; every later bit at a full period.
  assign tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      rxs_dly_q <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rxs_dly_q <= rxs_dly_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (tick) state_d = rxs ? IDLE : DATA;
      DATA:    if (tick && bit_cnt_q == 3'd7) state_d = PARITY;
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sync_d    = {sync_q[0], rx_data_in};
    rxs_dly_d = rxs;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    if (state_q == IDLE) begin
      cnt_d     = '0;
      bit_cnt_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      DATA: if (tick) begin
        shift_d   = {rxs, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      PARITY: if (tick) parity_d = rxs;
      STOP: if (tick) begin
        // Errored frames still publish their byte; flags hold until the next frame.
        data_d  = shift_q;
        perr_d  = (^shift_q) ^ parity_q;
        ferr_d  = ~rxs;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_busy       = (state_q != IDLE);
    rx_data_out   = data_q;
    rx_valid      = valid_q;
    rx_parity_err = perr_q;
    rx_frame_err  = ferr_q;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link, sitting directly downstream of the transmit top level. It consumes the serial line the transmitter drives (start bit, 8 data bits LSB-first, even parity bit, stop bit) and recovers each byte into a parallel register. It reports a one-cycle valid strobe plus parity and framing error flags. Bit timing comes from a fixed clocks-per-bit count with mid-bit sampling; the line input is asynchronous and is synchronised internally.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..65535; counter width is $clog2(CLKS_PER_BIT)
- clk  input  1  system clock; all state on rising edge
- rstn  input  1  asynchronous active-low reset
- rx_data_in  input  1  serial line; idle high; asynchronous to clk
- rx_data_out  output  8  last received byte, held until the next frame completes
- rx_valid  output  1  one-cycle pulse: rx_data_out and the error flags updated
- rx_parity_err  output  1  even-parity mismatch on the last frame
- rx_frame_err  output  1  stop bit sampled low on the last frame
- rx_busy  output  1  high from start-bit detection until the stop-bit sample

## Operation
- Synchroniser: two flops on rx_data_in, both reset to 1. Only the second-stage value (rxs) is used. rxs_d is rxs delayed one cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: bit counter = 0. A falling edge (rxs_d=1, rxs=0) moves to START and clears the cycle counter.
- START: at cycle count CLKS_PER_BIT/2-1 (floor), sample rxs.
  - rxs=1: false start; return to IDLE with no output change.
  - rxs=0: go to DATA and clear the counter.
- DATA: sample rxs every CLKS_PER_BIT cycles (count CLKS_PER_BIT-1), i.e. at bit centres. Shift right into the shift register so bit 0 is the first data bit. After the 8th sample, go to PARITY.
- PARITY: sample at bit centre and store the parity bit; go to STOP.
- STOP: sample at bit centre, then on the same edge:
  - load rx_data_out from the shift register;
  - rx_parity_err = XOR of the 8 data bits XOR the parity bit (nonzero means error);
  - rx_frame_err = ~stop_sample;
  - assert rx_valid;
  - go to IDLE.
- A frame with errors still updates rx_data_out and pulses rx_valid.
- Error flags hold until the next rx_valid.
- Returning to IDLE at mid-stop lets a back-to-back start bit (falling edge at the stop/start boundary) be detected.
- rx_busy = (state != IDLE).
- Counter arithmetic: unsigned, wraps only by explicit clear. It never exceeds CLKS_PER_BIT-1.

## Timing
- Reset (asynchronous, active-low, any state): state=IDLE, counters=0, shift register=0, rx_data_out=8'h00, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0, synchroniser flops=1.
- Reset mid-frame: the partial frame is discarded, no rx_valid, and the outputs return to their reset values.
- Input to detection latency: a line falling edge is seen by the FSM 2-3 clk later (synchroniser). rx_busy rises on the clock after detection.
- Sample points: with CLKS_PER_BIT=16, the start bit is checked 8 cycles after detection, then each later bit every 16 cycles.
- Total from detection to rx_valid: CLKS_PER_BIT/2 + 10*CLKS_PER_BIT cycles. rx_valid is registered high for exactly 1 cycle. rx_busy falls on the same edge rx_valid rises.
- Line glitch shorter than CLKS_PER_BIT/2 cycles at idle: rejected as a false start; rx_busy pulses, rx_valid stays 0.
- Line held low continuously (break): the frame completes with rx_frame_err=1. A new frame is not started until a fresh falling edge.

## Test plan
- Reset: assert rstn=0 mid-DATA of a frame, release, keep the line idle -> all outputs 0, no rx_valid; the next clean frame 0x3C is received correctly.
- Single frame, CLKS_PER_BIT=16, byte 0xA5, parity 0, stop 1 -> one rx_valid pulse; rx_data_out=8'hA5; both error flags 0; detection-to-valid = 168 cycles.
- Parity error: byte 0x01 sent with parity 0 -> rx_valid, rx_data_out=8'h01, rx_parity_err=1, rx_frame_err=0. The next good frame 0x01 with parity 1 clears the flag.
- Framing error: byte 0xFF, parity 0, stop bit driven 0 -> rx_data_out=8'hFF, rx_frame_err=1. Line returns high and a following 0x55 frame is received cleanly.
- False start: 4-cycle low glitch on an idle line -> no rx_valid, rx_data_out unchanged, FSM back in IDLE.
- Back-to-back loopback: transmitter top (bit period matched) sends 0x00, 0xFF, 0x5A with no idle gap -> three rx_valid pulses with 0x00, 0xFF, 0x5A in order, no error flags.
